// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and limits for the bit-serial adder sequencer.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/half_adder.sv
// Basic half adder cell: s = a ^ b, c = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_fa_slice.sv
// 1-bit full adder built from two half_adder cells; purely combinational.
module serial_fa_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1, c1, c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (ci),
    .s (s),
    .c (c2)
  );

  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: latches operands on start, adds one bit pair per clock LSB first.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_width_chk
      $error("serial_add_ctrl: WIDTH out of range 2..32");
    end
  endgenerate

  state_t           state, state_nxt;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;

  serial_fa_slice u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last = (cnt == CNT_LAST);
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
          load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter holds at CNT_LAST on the final shift instead of wrapping; the next load clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == ST_SHIFT) begin
      sum   <= {fa_s, sum[WIDTH-1:1]};
      carry <= fa_c;
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      if (last) cout <= fa_c;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule
